parity_frame_gen: RTL and testbench

PARITY_FRAME_GEN -- requirements
Module: parity_frame_gen

---
 rtl/parity_pkg.sv | 12 +
 rtl/parity_reduce.sv | 12 +
 rtl/parity_frame_gen.sv | 148 ++++++++++++++
 tb/tb_parity_frame_gen.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/parity_pkg.sv
// Shared types and default sizing for the parity frame generator.
package parity_pkg;

  typedef enum logic {
    S_DATA  = 1'b0,
    S_TRAIL = 1'b1
  } state_e;

  localparam int DATA_W_DEF    = 4;
  localparam int MAX_WORDS_DEF = 16;

endpackage

// File: rtl/parity_reduce.sv
// XOR reduction of a word, optionally inverted for odd parity.
module parity_reduce #(
  parameter int DATA_W = 4
) (
  input  logic [DATA_W-1:0] data,
  input  logic              odd,
  output logic              par
);

  assign par = (^data) ^ odd;

endmodule

// File: rtl/parity_frame_gen.sv
// Per-word parity tagging with a frame-parity trailer beat; frames longer
// than MAX_WORDS are cut short and their trailer is flagged with out_err.
module parity_frame_gen
  import parity_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int MAX_WORDS = MAX_WORDS_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              odd_mode,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_wpar,
  output logic              out_trailer,
  output logic              out_last,
  output logic              out_err,
  output logic              out_valid,
  input  logic              out_ready
);

  localparam int CNT_W = $clog2(MAX_WORDS + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WORDS);

  state_e            state_q, state_d;
  logic              acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              mode_q, mode_d;
  logic              perr_q, perr_d;

  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_wpar_q, out_wpar_d;
  logic              out_trailer_q, out_trailer_d;
  logic              out_last_q, out_last_d;
  logic              out_err_q, out_err_d;
  logic              out_valid_q, out_valid_d;

  logic              free_slot;
  logic              in_fire;
  logic              cur_mode;
  logic              word_par;
  logic              trail_par;
  logic [CNT_W-1:0]  cnt_inc;

  assign free_slot = !out_valid_q || out_ready;
  assign in_ready  = (state_q == S_DATA) && free_slot;
  assign in_fire   = in_valid && in_ready;
  assign cnt_inc   = cnt_q + CNT_W'(1);

  // The first word of a frame uses the live mode pin; later words use the captured copy.
  assign cur_mode = (cnt_q == '0) ? odd_mode : mode_q;

  parity_reduce #(.DATA_W(DATA_W)) u_word_par (
    .data (in_data),
    .odd  (cur_mode),
    .par  (word_par)
  );

  parity_reduce #(.DATA_W(1)) u_trail_par (
    .data (acc_q),
    .odd  (mode_q),
    .par  (trail_par)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_DATA;
      acc_q         <= 1'b0;
      cnt_q         <= '0;
      mode_q        <= 1'b0;
      perr_q        <= 1'b0;
      out_data_q    <= '0;
      out_wpar_q    <= 1'b0;
      out_trailer_q <= 1'b0;
      out_last_q    <= 1'b0;
      out_err_q     <= 1'b0;
      out_valid_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      acc_q         <= acc_d;
      cnt_q         <= cnt_d;
      mode_q        <= mode_d;
      perr_q        <= perr_d;
      out_data_q    <= out_data_d;
      out_wpar_q    <= out_wpar_d;
      out_trailer_q <= out_trailer_d;
      out_last_q    <= out_last_d;
      out_err_q     <= out_err_d;
      out_valid_q   <= out_valid_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    acc_d         = acc_q;
    cnt_d         = cnt_q;
    mode_d        = mode_q;
    perr_d        = perr_q;
    out_data_d    = out_data_q;
    out_wpar_d    = out_wpar_q;
    out_trailer_d = out_trailer_q;
    out_last_d    = out_last_q;
    out_err_d     = out_err_q;
    out_valid_d   = out_valid_q;

    if (in_fire) begin
      out_valid_d   = 1'b1;
      out_data_d    = in_data;
      out_wpar_d    = word_par;
      out_trailer_d = 1'b0;
      out_last_d    = 1'b0;
      out_err_d     = 1'b0;
      acc_d         = acc_q ^ (^in_data);
      cnt_d         = cnt_inc;
      if (cnt_q == '0) mode_d = odd_mode;
      if (in_last) begin
        state_d = S_TRAIL;
      end else if (cnt_inc == MAX_CNT) begin
        state_d = S_TRAIL;
        perr_d  = 1'b1;
      end
    end else if (state_q == S_TRAIL && free_slot) begin
      out_valid_d   = 1'b1;
      out_data_d    = '0;
      out_wpar_d    = trail_par;
      out_trailer_d = 1'b1;
      out_last_d    = 1'b1;
      out_err_d     = perr_q;
      acc_d         = 1'b0;
      cnt_d         = '0;
      perr_d        = 1'b0;
      state_d       = S_DATA;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  assign out_data    = out_data_q;
  assign out_wpar    = out_wpar_q;
  assign out_trailer = out_trailer_q;
  assign out_last    = out_last_q;
  assign out_err     = out_err_q;
  assign out_valid   = out_valid_q;

endmodule

// File: tb/tb_parity_frame_gen.sv
// Directed bench for parity_frame_gen: one 16-word instance and one 3-word
// instance for truncation; beats are compared as {valid,data,wpar,trailer,last,err}.
module tb_parity_frame_gen;

  logic       clk;
  logic       rst_n;
  logic       odd_mode, in_valid, in_last, out_ready;
  logic [3:0] in_data;
  logic       in_ready, out_wpar, out_trailer, out_last, out_err, out_valid;
  logic [3:0] out_data;

  logic       b_odd_mode, b_in_valid, b_in_last, b_out_ready;
  logic [3:0] b_in_data;
  logic       b_in_ready, b_out_wpar, b_out_trailer, b_out_last, b_out_err, b_out_valid;
  logic [3:0] b_out_data;

  logic [8:0] beat_a, beat_b;
  int         errors = 0;
  int         checks = 0;

  assign beat_a = {out_valid, out_data, out_wpar, out_trailer, out_last, out_err};
  assign beat_b = {b_out_valid, b_out_data, b_out_wpar, b_out_trailer, b_out_last, b_out_err};

  parity_frame_gen #(.DATA_W(4), .MAX_WORDS(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .odd_mode(odd_mode), .in_data(in_data),
    .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .out_data(out_data), .out_wpar(out_wpar), .out_trailer(out_trailer),
    .out_last(out_last), .out_err(out_err), .out_valid(out_valid),
    .out_ready(out_ready)
  );

  parity_frame_gen #(.DATA_W(4), .MAX_WORDS(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .odd_mode(b_odd_mode), .in_data(b_in_data),
    .in_valid(b_in_valid), .in_last(b_in_last), .in_ready(b_in_ready),
    .out_data(b_out_data), .out_wpar(b_out_wpar), .out_trailer(b_out_trailer),
    .out_last(b_out_last), .out_err(b_out_err), .out_valid(b_out_valid),
    .out_ready(b_out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    odd_mode = 0; in_valid = 0; in_last = 0; in_data = '0; out_ready = 1;
    b_odd_mode = 0; b_in_valid = 0; b_in_last = 0; b_in_data = '0; b_out_ready = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (beat_a !== 9'b0) begin errors++; $display("FAIL reset_outputs got=%b exp=%b", beat_a, 9'b0); end
    step();
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_even();
    step();
    in_valid = 1; in_data = 4'b1011; in_last = 0; odd_mode = 0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL even_ready got=%b exp=1", in_ready); end
    step();
    in_data = 4'b0001; in_last = 1;
    @(negedge clk);
    checks++;
    if (beat_a !== 9'b1_1011_1_000) begin errors++; $display("FAIL even_w1 got=%b exp=%b", beat_a, 9'b1_1011_1_000); end
    step();
    in_valid = 0; in_last = 0;
    @(negedge clk);
    checks++;
    if (beat_a !== 9'b1_0001_1_000) begin errors++; $display("FAIL even_w2 got=%b exp=%b", beat_a, 9'b1_0001_1_000); end
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL even_trail_ready got=%b exp=0", in_ready); end
    step();
    @(negedge clk);
    checks++;
    if (beat_a !== 9'b1_0000_0_110) begin errors++; $display("FAIL even_trailer got=%b exp=%b", beat_a, 9'b1_0000_0_110); end
    step();
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL even_idle got valid=%b ready=%b exp valid=0 ready=1", out_valid, in_ready);
    end
  endtask

  task automatic test_odd();
    step();
    in_valid = 1; in_data = 4'b1011; in_last = 0; odd_mode = 1;
    step();
    in_data = 4'b0001; in_last = 1; odd_mode = 0;
    @(negedge clk);
    checks++;
    if (beat_a !== 9'b1_1011_0_000) begin errors++; $display("FAIL odd_w1 got=%b exp=%b", beat_a, 9'b1_1011_0_000); end
    step();
    in_valid = 0; in_last = 0;
    @(negedge clk);
    checks++;
    if (beat_a !== 9'b1_0001_0_000) begin errors++; $display("FAIL odd_w2 got=%b exp=%b", beat_a, 9'b1_0001_0_000); end
    step();
    @(negedge clk);
    checks++;
    if (beat_a !== 9'b1_0000_1_110) begin errors++; $display("FAIL odd_trailer got=%b exp=%b", beat_a, 9'b1_0000_1_110); end
    step();
  endtask

  task automatic test_exhaustive();
    logic [3:0] pv;
    logic [8:0] exp;
    odd_mode = 0;
    for (int i = 0; i < 16; i++) begin
      in_valid = 1; in_data = 4'(i); in_last = (i == 15);
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL exh_ready word=%0d got=%b exp=1", i, in_ready); end
      if (i > 0) begin
        pv = 4'(i - 1);
        exp = {1'b1, pv, ^pv, 3'b000};
        checks++;
        if (beat_a !== exp) begin errors++; $display("FAIL exh_word %0d got=%b exp=%b", i - 1, beat_a, exp); end
      end
      step();
    end
    in_valid = 0; in_last = 0;
    @(negedge clk);
    checks++;
    if (beat_a !== 9'b1_1111_0_000) begin errors++; $display("FAIL exh_word 15 got=%b exp=%b", beat_a, 9'b1_1111_0_000); end
    step();
    @(negedge clk);
    checks++;
    if (beat_a !== 9'b1_0000_0_110) begin errors++; $display("FAIL exh_trailer got=%b exp=%b", beat_a, 9'b1_0000_0_110); end
    step();
  endtask

  task automatic test_trunc();
    b_in_valid = 1; b_in_data = 4'b0001; b_in_last = 0; b_odd_mode = 0;
    @(negedge clk);
    checks++;
    if (b_in_ready !== 1'b1) begin errors++; $display("FAIL trunc_ready0 got=%b exp=1", b_in_ready); end
    step();
    b_in_data = 4'b0011;
    @(negedge clk);
    checks++;
    if (beat_b !== 9'b1_0001_1_000) begin errors++; $display("FAIL trunc_w1 got=%b exp=%b", beat_b, 9'b1_0001_1_000); end
    step();
    b_in_data = 4'b0111;
    @(negedge clk);
    checks++;
    if (beat_b !== 9'b1_0011_0_000) begin errors++; $display("FAIL trunc_w2 got=%b exp=%b", beat_b, 9'b1_0011_0_000); end
    step();
    b_in_data = 4'b0100;
    @(negedge clk);
    checks++;
    if (beat_b !== 9'b1_0111_1_000) begin errors++; $display("FAIL trunc_w3 got=%b exp=%b", beat_b, 9'b1_0111_1_000); end
    checks++;
    if (b_in_ready !== 1'b0) begin errors++; $display("FAIL trunc_block got=%b exp=0", b_in_ready); end
    step();
    @(negedge clk);
    checks++;
    if (beat_b !== 9'b1_0000_0_111) begin errors++; $display("FAIL trunc_trailer got=%b exp=%b", beat_b, 9'b1_0000_0_111); end
    step();
    b_in_data = 4'b0101;
    @(negedge clk);
    checks++;
    if (beat_b !== 9'b1_0100_1_000) begin errors++; $display("FAIL trunc_w4 got=%b exp=%b", beat_b, 9'b1_0100_1_000); end
    step();
    b_in_data = 4'b0000; b_in_last = 1;
    @(negedge clk);
    checks++;
    if (beat_b !== 9'b1_0101_0_000) begin errors++; $display("FAIL trunc_w5 got=%b exp=%b", beat_b, 9'b1_0101_0_000); end
    step();
    b_in_valid = 0; b_in_last = 0;
    @(negedge clk);
    checks++;
    if (beat_b !== 9'b1_0000_0_000) begin errors++; $display("FAIL trunc_w6 got=%b exp=%b", beat_b, 9'b1_0000_0_000); end
    step();
    @(negedge clk);
    checks++;
    if (beat_b !== 9'b1_0000_1_110) begin errors++; $display("FAIL trunc_trailer2 got=%b exp=%b", beat_b, 9'b1_0000_1_110); end
    step();
  endtask

  task automatic test_stall();
    in_valid = 1; in_data = 4'b0110; in_last = 0; odd_mode = 0; out_ready = 1;
    step();
    in_data = 4'b1000; in_last = 1;
    @(negedge clk);
    checks++;
    if (beat_a !== 9'b1_0110_0_000) begin errors++; $display("FAIL stall_w1 got=%b exp=%b", beat_a, 9'b1_0110_0_000); end
    step();
    in_data = 4'b0011; in_last = 1;
    @(negedge clk);
    checks++;
    if (beat_a !== 9'b1_1000_1_000) begin errors++; $display("FAIL stall_w2 got=%b exp=%b", beat_a, 9'b1_1000_1_000); end
    step();
    out_ready = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if (beat_a !== 9'b1_0000_1_110 || in_ready !== 1'b0) begin
        errors++; $display("FAIL stall_hold cyc=%0d got beat=%b ready=%b exp beat=%b ready=0", k, beat_a, in_ready, 9'b1_0000_1_110);
      end
      step();
    end
    out_ready = 1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_release_ready got=%b exp=1", in_ready); end
    step();
    in_valid = 0; in_last = 0;
    @(negedge clk);
    checks++;
    if (beat_a !== 9'b1_0011_0_000) begin errors++; $display("FAIL stall_next_word got=%b exp=%b", beat_a, 9'b1_0011_0_000); end
    step();
    @(negedge clk);
    checks++;
    if (beat_a !== 9'b1_0000_0_110) begin errors++; $display("FAIL stall_next_trailer got=%b exp=%b", beat_a, 9'b1_0000_0_110); end
    step();
  endtask

  task automatic test_reset_midframe();
    in_valid = 1; in_data = 4'b0001; in_last = 0; odd_mode = 0;
    step();
    in_data = 4'b0011;
    @(negedge clk);
    checks++;
    if (beat_a !== 9'b1_0001_1_000) begin errors++; $display("FAIL rstm_w1 got=%b exp=%b", beat_a, 9'b1_0001_1_000); end
    step();
    in_valid = 0;
    rst_n = 1'b0;
    #1;
    checks++;
    if (beat_a !== 9'b0) begin errors++; $display("FAIL rstm_async got=%b exp=%b", beat_a, 9'b0); end
    step();
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || beat_a !== 9'b0) begin
      errors++; $display("FAIL rstm_release got ready=%b beat=%b exp ready=1 beat=0", in_ready, beat_a);
    end
    step();
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL rstm_no_trailer got=%b exp=0", out_valid); end
    step();
    in_valid = 1; in_data = 4'b0100; in_last = 1;
    step();
    in_valid = 0; in_last = 0;
    @(negedge clk);
    checks++;
    if (beat_a !== 9'b1_0100_1_000) begin errors++; $display("FAIL rstm_new_word got=%b exp=%b", beat_a, 9'b1_0100_1_000); end
    step();
    @(negedge clk);
    checks++;
    if (beat_a !== 9'b1_0000_1_110) begin errors++; $display("FAIL rstm_new_trailer got=%b exp=%b", beat_a, 9'b1_0000_1_110); end
    step();
  endtask

  initial begin
    test_reset();
    test_even();
    test_odd();
    test_exhaustive();
    test_trunc();
    test_stall();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
